// File: rtl/sram_2p_pkg.sv
// sram_2p_pkg: write-mode constants and init FSM state type shared by the SRAM block
package sram_2p_pkg;
  localparam int WM_NOCHANGE = 0;
  localparam int WM_WTHROUGH = 1;
  localparam int WM_RDFIRST  = 2;
  typedef enum logic {INIT, READY} init_state_e;
endpackage

// File: rtl/sram_2p_init_fsm.sv
// sram_2p_init_fsm: after reset, sweeps every address once with a write strobe, then parks in READY
module sram_2p_init_fsm
  import sram_2p_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    we_o,
  output logic [P_ADDR_WIDTH-1:0] addr_o,
  output logic                    busy_o
);
  init_state_e             state_q, state_d;
  logic [P_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                    last;
  assign last = &cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // counter stops on the last address so READY never re-enters the sweep
  always_comb begin
    state_d = (state_q == INIT && last) ? READY : state_q;
    cnt_d   = (state_q == INIT && !last) ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    busy_o = (state_q == INIT);
    we_o   = busy_o;
    addr_o = cnt_q;
  end
endmodule

// File: rtl/sram_2p_sync.sv
// sram_2p_sync: true dual-port synchronous SRAM with bit masks, per-port write modes,
// optional output register, power-on clear sweep and collision flags
module sram_2p_sync
  import sram_2p_pkg::*;
#(
  parameter int                      P_DATA_WIDTH = 20,
  parameter int                      P_ADDR_WIDTH = 9,
  parameter int                      P_A_WMODE    = WM_NOCHANGE,
  parameter int                      P_B_WMODE    = WM_NOCHANGE,
  parameter int                      P_OUT_REG    = 0,
  parameter logic [P_DATA_WIDTH-1:0] P_INIT_VALUE = '0
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    A_MEN,
  input  logic                    A_WEN,
  input  logic                    A_REN,
  input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
  input  logic [P_DATA_WIDTH-1:0] A_DIN,
  input  logic [P_DATA_WIDTH-1:0] A_BM,
  output logic [P_DATA_WIDTH-1:0] A_DOUT,
  output logic                    A_DVALID,
  input  logic                    B_MEN,
  input  logic                    B_WEN,
  input  logic                    B_REN,
  input  logic [P_ADDR_WIDTH-1:0] B_ADDR,
  input  logic [P_DATA_WIDTH-1:0] B_DIN,
  input  logic [P_DATA_WIDTH-1:0] B_BM,
  output logic [P_DATA_WIDTH-1:0] B_DOUT,
  output logic                    B_DVALID,
  output logic                    INIT_BUSY,
  output logic                    COLL_WW,
  output logic                    COLL_RW
);
  localparam int DEPTH = 2**P_ADDR_WIDTH;
  logic [P_DATA_WIDTH-1:0] mem [DEPTH];
  logic                    init_we, busy, same;
  logic [P_ADDR_WIDTH-1:0] init_addr;
  logic                    a_wr, a_rd, b_wr, b_rd, a_rvld, b_rvld;
  logic [P_DATA_WIDTH-1:0] a_old, b_old, a_new, a_fin, b_new, a_rdata, b_rdata;
  logic [P_DATA_WIDTH-1:0] a_d1_q, a_d1_d, a_d2_q, a_d2_d, b_d1_q, b_d1_d, b_d2_q, b_d2_d;
  logic                    a_v1_q, a_v1_d, a_v2_q, a_v2_d, b_v1_q, b_v1_d, b_v2_q, b_v2_d;
  logic                    coll_ww_q, coll_ww_d, coll_rw_q, coll_rw_d;
  sram_2p_init_fsm #(.P_ADDR_WIDTH(P_ADDR_WIDTH)) u_init (
    .clk_i (CLK),
    .rst_ni(RSTN),
    .we_o  (init_we),
    .addr_o(init_addr),
    .busy_o(busy)
  );
  // B is merged on top of A's result so overlapping masked bits end up with B data
  always_comb begin
    a_wr    = A_MEN & ~busy & A_WEN;
    a_rd    = A_MEN & ~busy & A_REN;
    b_wr    = B_MEN & ~busy & B_WEN;
    b_rd    = B_MEN & ~busy & B_REN;
    same    = (A_ADDR == B_ADDR);
    a_old   = mem[A_ADDR];
    b_old   = mem[B_ADDR];
    a_new   = (a_old & ~A_BM) | (A_DIN & A_BM);
    b_new   = (((a_wr & same) ? a_new : b_old) & ~B_BM) | (B_DIN & B_BM);
    a_fin   = (b_wr & same) ? b_new : a_new;
    a_rvld  = a_rd & (~A_WEN | (P_A_WMODE != WM_NOCHANGE));
    b_rvld  = b_rd & (~B_WEN | (P_B_WMODE != WM_NOCHANGE));
    a_rdata = (A_WEN & (P_A_WMODE == WM_WTHROUGH)) ? a_fin : a_old;
    b_rdata = (B_WEN & (P_B_WMODE == WM_WTHROUGH)) ? b_new : b_old;
  end
  always_ff @(posedge CLK)
    if (init_we) mem[init_addr] <= P_INIT_VALUE;
    else begin
      if (a_wr) mem[A_ADDR] <= a_fin;
      if (b_wr) mem[B_ADDR] <= b_new;
    end
  always_comb begin
    a_d1_d    = a_rvld ? a_rdata : a_d1_q;
    a_v1_d    = a_rvld;
    a_d2_d    = a_v1_q ? a_d1_q : a_d2_q;
    a_v2_d    = a_v1_q;
    b_d1_d    = b_rvld ? b_rdata : b_d1_q;
    b_v1_d    = b_rvld;
    b_d2_d    = b_v1_q ? b_d1_q : b_d2_q;
    b_v2_d    = b_v1_q;
    coll_ww_d = a_wr & b_wr & same & |(A_BM & B_BM);
    coll_rw_d = same & ((a_rd & ~A_WEN & b_wr) | (b_rd & ~B_WEN & a_wr));
  end
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      a_d1_q    <= '0;
      a_v1_q    <= 1'b0;
      a_d2_q    <= '0;
      a_v2_q    <= 1'b0;
      b_d1_q    <= '0;
      b_v1_q    <= 1'b0;
      b_d2_q    <= '0;
      b_v2_q    <= 1'b0;
      coll_ww_q <= 1'b0;
      coll_rw_q <= 1'b0;
    end else begin
      a_d1_q    <= a_d1_d;
      a_v1_q    <= a_v1_d;
      a_d2_q    <= a_d2_d;
      a_v2_q    <= a_v2_d;
      b_d1_q    <= b_d1_d;
      b_v1_q    <= b_v1_d;
      b_d2_q    <= b_d2_d;
      b_v2_q    <= b_v2_d;
      coll_ww_q <= coll_ww_d;
      coll_rw_q <= coll_rw_d;
    end
  assign A_DOUT    = (P_OUT_REG != 0) ? a_d2_q : a_d1_q;
  assign A_DVALID  = (P_OUT_REG != 0) ? a_v2_q : a_v1_q;
  assign B_DOUT    = (P_OUT_REG != 0) ? b_d2_q : b_d1_q;
  assign B_DVALID  = (P_OUT_REG != 0) ? b_v2_q : b_v1_q;
  assign INIT_BUSY = busy;
  assign COLL_WW   = coll_ww_q;
  assign COLL_RW   = coll_rw_q;
endmodule
